hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch/jump flush, EX operand forwarding and
// event counters, using a shadow copy of the EX/MEM/WB register fields.
module hazard_unit #(
    parameter int unsigned INIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        uses_rt_ID,
    input  logic [4:0]  dest_ID,
    input  logic        wr_ID,
    input  logic        ld_ID,
    input  logic        jump_ID,
    input  logic        br_taken_MEM,
    output logic        stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        exmem_flush,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic [15:0] lu_count,
    output logic [15:0] br_count
);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       wr;
        logic       ld;
    } shadow_t;

    typedef enum logic {StInit, StRun} state_e;

    state_e      state_q, state_d;
    logic [15:0] init_cnt_q, init_cnt_d;
    shadow_t     ex_q, mem_q, wb_q;
    shadow_t     id_fields;
    logic [15:0] lu_cnt_q, br_cnt_q;
    logic        load_use;
    logic        lu_inc, br_inc;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input shadow_t m,
                                           input shadow_t w);
        if (m.wr && m.dest != 5'd0 && m.dest == src) begin
            return 2'b10;
        end else if (w.wr && w.dest != 5'd0 && w.dest == src) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign id_fields = '{rs: rs_ID, rt: rt_ID, dest: dest_ID, wr: wr_ID, ld: ld_ID};

    assign load_use = ex_q.ld && ex_q.wr && ex_q.dest != 5'd0 &&
                      (ex_q.dest == rs_ID || (uses_rt_ID && ex_q.dest == rt_ID));

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        stall       = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        lu_inc      = 1'b0;
        br_inc      = 1'b0;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q - 16'd1;
                if (init_cnt_q <= 16'd1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                stall      = 1'b1;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                if (br_taken_MEM) begin
                    ifid_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    stall       = 1'b0;
                    br_inc      = 1'b1;
                end else if (load_use) begin
                    // Jump held in ID is simply re-evaluated once the bubble clears.
                    stall      = 1'b0;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    lu_inc     = 1'b1;
                end else if (jump_ID) begin
                    ifid_flush = 1'b1;
                end
            end
        endcase
        fwdA = fwd_sel(ex_q.rs, mem_q, wb_q);
        fwdB = fwd_sel(ex_q.rt, mem_q, wb_q);
        if (reset) begin
            stall       = 1'b0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            exmem_flush = 1'b0;
            fwdA        = 2'b00;
            fwdB        = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= 16'(INIT_CYCLES);
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            lu_cnt_q   <= '0;
            br_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ex_q       <= stall ? id_fields : '0;
            mem_q      <= exmem_flush ? '0 : ex_q;
            wb_q       <= mem_q;
            if (lu_inc && lu_cnt_q != 16'hFFFF) begin
                lu_cnt_q <= lu_cnt_q + 16'd1;
            end
            if (br_inc && br_cnt_q != 16'hFFFF) begin
                br_cnt_q <= br_cnt_q + 16'd1;
            end
        end
    end

    assign lu_count = lu_cnt_q;
    assign br_count = br_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector records pushed to a scoreboard queue as they
// are driven, popped and compared just before the following rising edge.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_ID, rt_ID, dest_ID;
    logic        uses_rt_ID, wr_ID, ld_ID, jump_ID, br_taken_MEM;
    logic        stall, pc_write, ifid_write, ifid_flush, exmem_flush;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] lu_count, br_count;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string       nm;
        bit          rst;
        logic [4:0]  rs, rt;
        bit          urt;
        logic [4:0]  dest;
        bit          wr, ld, jmp, br;
        logic [4:0]  ctl;   // {stall, pc_write, ifid_write, ifid_flush, exmem_flush}
        logic [1:0]  fa, fb;
        logic [15:0] lu, brc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    hazard_unit #(.INIT_CYCLES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .uses_rt_ID   (uses_rt_ID),
        .dest_ID      (dest_ID),
        .wr_ID        (wr_ID),
        .ld_ID        (ld_ID),
        .jump_ID      (jump_ID),
        .br_taken_MEM (br_taken_MEM),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .exmem_flush  (exmem_flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .lu_count     (lu_count),
        .br_count     (br_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(string nm, bit rst, logic [4:0] rs, logic [4:0] rt, bit urt,
                                logic [4:0] dest, bit wr, bit ld, bit jmp, bit br,
                                logic [4:0] ctl, logic [1:0] fa, logic [1:0] fb,
                                logic [15:0] lu, logic [15:0] brc);
        vec_t v;
        v.nm = nm; v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.dest = dest;
        v.wr = wr; v.ld = ld; v.jmp = jmp; v.br = br; v.ctl = ctl;
        v.fa = fa; v.fb = fb; v.lu = lu; v.brc = brc;
        return v;
    endfunction

    task automatic cmp(input string nm, input string what, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_front();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: empty queue at %0t, got 0 expected 1 entry", $time);
            return;
        end
        e = sb.pop_front();
        cmp(e.nm, "ctl", 16'({stall, pc_write, ifid_write, ifid_flush, exmem_flush}),
            16'(e.ctl));
        cmp(e.nm, "fwdA", 16'(fwdA), 16'(e.fa));
        cmp(e.nm, "fwdB", 16'(fwdB), 16'(e.fb));
        cmp(e.nm, "lu_count", lu_count, e.lu);
        cmp(e.nm, "br_count", br_count, e.brc);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        reset        = v.rst;
        rs_ID        = v.rs;
        rt_ID        = v.rt;
        uses_rt_ID   = v.urt;
        dest_ID      = v.dest;
        wr_ID        = v.wr;
        ld_ID        = v.ld;
        jump_ID      = v.jmp;
        br_taken_MEM = v.br;
        sb.push_back(v);
        #2;
        check_front();
    endtask

    initial begin
        reset = 1'b1;
        rs_ID = '0; rt_ID = '0; dest_ID = '0;
        uses_rt_ID = 1'b0; wr_ID = 1'b0; ld_ID = 1'b0; jump_ID = 1'b0; br_taken_MEM = 1'b0;
        repeat (2) @(posedge clk);

        //          name         rst rs rt urt dst wr ld j  b  ctl       fa     fb     lu  br
        tbl.push_back(mk("rst_hold",  1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("init0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("init1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("init2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("run0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("lw5",       0, 1, 0, 0, 5, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("lu_stall",  0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("lu_resume", 0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("fwd_wb",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b01, 2'b00, 1, 0));
        tbl.push_back(mk("w3a",       0, 0, 0, 0, 3, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("w3b",       0, 0, 0, 0, 3, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("use3",      0, 3, 3, 1, 7, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("fwd_mem",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b10, 2'b10, 1, 0));
        tbl.push_back(mk("w0a",       0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("w0b",       0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("use0",      0, 0, 0, 1, 8, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("fwd_r0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("lw4",       0, 0, 0, 0, 4, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("br_all",    0, 4, 0, 0, 0, 0, 0, 1, 1, 5'b01111, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("post_br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk("jump",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk("post_j",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk("lw9",       0, 0, 0, 0, 9, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk("jr_lu",     0, 9, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 2'b00, 1, 1));
        tbl.push_back(mk("jr_retry",  0, 9, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 2'b00, 2'b00, 2, 1));
        tbl.push_back(mk("post_jr",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b01, 2'b00, 2, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Saturation: preload the counter near its ceiling instead of 65536 real events.
        @(negedge clk);
        force dut.lu_cnt_q = 16'hFFFE;
        #1;
        release dut.lu_cnt_q;
        step(mk("sat_lw",    0, 1, 0, 0, 5, 1, 1, 0, 0, 5'b11100, 2'b00, 2'b00, 16'hFFFE, 1));
        step(mk("sat_use1",  0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 16'hFFFE, 1));
        step(mk("sat_hold",  0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 16'hFFFF, 1));
        step(mk("sat_lw2",   0, 1, 0, 0, 5, 1, 1, 0, 0, 5'b11100, 2'b01, 2'b00, 16'hFFFF, 1));
        step(mk("sat_use2",  0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 16'hFFFF, 1));
        step(mk("sat_hold2", 0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 16'hFFFF, 1));

        // Reset arriving while a load-use stall is active.
        step(mk("rs_lw",     0, 1, 0, 0, 5, 1, 1, 0, 0, 5'b11100, 2'b01, 2'b00, 16'hFFFF, 1));
        step(mk("rs_mid",    1, 5, 2, 1, 6, 1, 0, 1, 1, 5'b00000, 2'b00, 2'b00, 16'hFFFF, 1));
        step(mk("rs_after1", 0, 5, 2, 1, 6, 1, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        step(mk("rs_after2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        step(mk("rs_after3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 0, 0));
        step(mk("rs_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2'b00, 2'b00, 0, 0));

        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
